hspi_frame_builder: RTL and testbench

// Upstream source for the HSPI transmitter, running in the clk_15MHz domain. Every PERIOD cycles it

---
 rtl/hspi_pkg.sv | 17 +
 rtl/hspi_pattern_src.sv | 35 +++
 rtl/hspi_frame_builder.sv | 154 +++++++++++++++
 tb/tb_hspi_frame_builder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hspi_pkg.sv
// Shared constants and types for the HSPI frame builder: frame markers,
// payload pattern selection, fill FSM states and the payload LFSR step.
package hspi_pkg;

  localparam logic [15:0] SYNC_WORD  = 16'h5AA5;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] CONST_WORD = 16'hA5A5;

  typedef enum logic [1:0] {PAT_INCR, PAT_LFSR, PAT_CONST, PAT_WALK} pat_mode_t;
  typedef enum logic {S_IDLE, S_FILL} fb_state_t;

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

endpackage

// File: rtl/hspi_pattern_src.sv
// Payload word generator. The LFSR advances only when step is asserted and is
// never reseeded, so the pseudo-random stream runs on across frames.
module hspi_pattern_src
  import hspi_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk_15MHz,
  input  logic              rst_n,
  input  pat_mode_t         mode,
  input  logic [ADDR_W-1:0] index,
  input  logic              step,
  output logic [DATA_W-1:0] word
);

  logic [15:0] lfsr;

  always_ff @(posedge clk_15MHz or negedge rst_n) begin
    if (!rst_n)    lfsr <= LFSR_SEED;
    else if (step) lfsr <= lfsr_next(lfsr);
  end

  always_comb begin
    word = '0;
    case (mode)
      PAT_INCR:  word = DATA_W'(index);
      PAT_LFSR:  word = DATA_W'(lfsr);
      PAT_CONST: word = DATA_W'(CONST_WORD);
      PAT_WALK:  word = DATA_W'(1) << (32'(index) % 32'd16);
      default:   word = '0;
    endcase
  end

endmodule

// File: rtl/hspi_frame_builder.sv
// Periodic framed test-packet writer into a ping-pong RAM, handing finished
// banks to the clk_sys HSPI side over a toggle req/ack handshake.
module hspi_frame_builder
  import hspi_pkg::*;
#(
  parameter int FRAME_WORDS = 512,
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 16,
  parameter int PERIOD      = 2097152
) (
  input  logic              clk_15MHz,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  output logic              buf_we,
  output logic              buf_bank,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              tx_req_tgl,
  output logic              tx_bank,
  input  logic              tx_ack_tgl,
  output logic [15:0]       frame_seq,
  output logic              busy,
  output logic              overrun
);

  localparam int TW = $clog2(PERIOD);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [ADDR_W-1:0] PAY_END = ADDR_W'(FRAME_WORDS - 2);

  fb_state_t         state, state_n;
  logic [TW-1:0]     timer;
  logic              tick, start, completing, fill_free;
  logic              fill_bank;
  logic [15:0]       seq;
  logic [DATA_W-1:0] cksum, pat_word, next_word;
  pat_mode_t         mode_q;
  logic [ADDR_W-1:0] nxt_idx;
  logic              pay_step;
  logic              ack_s1, ack_s2, ack_q, ack_edge;
  logic              if_vld, pend_vld, pend_bank;
  logic              cand_vld, cand_bank, chan_free;

  assign tick       = enable && (timer == TW'(PERIOD - 1));
  assign fill_free  = !(if_vld && tx_bank == fill_bank) && !(pend_vld && pend_bank == fill_bank);
  assign start      = (state == S_IDLE) && tick && fill_free;
  assign completing = (state == S_FILL) && (buf_addr == LAST);
  assign nxt_idx    = buf_addr + ADDR_W'(1);
  assign pay_step   = (state == S_FILL) && !completing && (mode_q == PAT_LFSR) &&
                      (nxt_idx >= ADDR_W'(2)) && (nxt_idx <= PAY_END);
  assign busy       = (state == S_FILL);
  assign ack_edge   = ack_s2 ^ ack_q;

  // A pending bank and a completing fill never coexist: both banks would be busy.
  assign cand_vld  = pend_vld || completing;
  assign cand_bank = pend_vld ? pend_bank : buf_bank;
  assign chan_free = !if_vld || ack_edge;

  always_comb begin
    next_word = pat_word;
    if (nxt_idx == ADDR_W'(1)) next_word = DATA_W'(seq);
    else if (nxt_idx == LAST)  next_word = cksum;
  end

  hspi_pattern_src #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pat (
    .clk_15MHz (clk_15MHz),
    .rst_n     (rst_n),
    .mode      (mode_q),
    .index     (nxt_idx),
    .step      (pay_step),
    .word      (pat_word)
  );

  always_ff @(posedge clk_15MHz or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_FILL;
      S_FILL:  if (completing) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_15MHz or negedge rst_n) begin
    if (!rst_n) begin
      timer      <= '0;
      fill_bank  <= 1'b0;
      seq        <= '0;
      cksum      <= '0;
      mode_q     <= PAT_INCR;
      ack_s1     <= 1'b0;
      ack_s2     <= 1'b0;
      ack_q      <= 1'b0;
      if_vld     <= 1'b0;
      pend_vld   <= 1'b0;
      pend_bank  <= 1'b0;
      buf_we     <= 1'b0;
      buf_bank   <= 1'b0;
      buf_addr   <= '0;
      buf_wdata  <= '0;
      tx_req_tgl <= 1'b0;
      tx_bank    <= 1'b0;
      frame_seq  <= '0;
      overrun    <= 1'b0;
    end else begin
      ack_s1 <= tx_ack_tgl;
      ack_s2 <= ack_s1;
      ack_q  <= ack_s2;
      timer  <= (!enable || tick) ? '0 : timer + TW'(1);

      if (tick && !start) overrun <= 1'b1;

      if (start) begin
        buf_we    <= 1'b1;
        buf_bank  <= fill_bank;
        buf_addr  <= '0;
        buf_wdata <= DATA_W'(SYNC_WORD);
        cksum     <= DATA_W'(SYNC_WORD);
        mode_q    <= pat_mode_t'(mode);
      end else if (state == S_FILL) begin
        if (completing) begin
          buf_we    <= 1'b0;
          buf_addr  <= '0;
          buf_wdata <= '0;
          frame_seq <= seq;
          seq       <= seq + 16'd1;
          fill_bank <= ~fill_bank;
        end else begin
          buf_addr  <= nxt_idx;
          buf_wdata <= next_word;
          if (nxt_idx != LAST) cksum <= cksum + next_word;
        end
      end

      if (cand_vld && chan_free) begin
        tx_bank    <= cand_bank;
        tx_req_tgl <= ~tx_req_tgl;
        if_vld     <= 1'b1;
        pend_vld   <= 1'b0;
      end else begin
        if (ack_edge) if_vld <= 1'b0;
        if (completing) begin
          pend_vld  <= 1'b1;
          pend_bank <= buf_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_hspi_frame_builder.sv
// Scoreboard bench: a frame-level model predicts ticks, frame contents and
// posts; a monitor compares every RAM write and every req toggle.
module tb_hspi_frame_builder;
  localparam int N = 16, AW = 4, DW = 16, PER = 600;

  logic          clk_15MHz = 1'b0;
  logic          rst_n = 1'b0, enable = 1'b0, tx_ack_tgl = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          buf_we, buf_bank, tx_req_tgl, tx_bank, busy, overrun;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_wdata;
  logic [15:0]   frame_seq;

  hspi_frame_builder #(.FRAME_WORDS(N), .ADDR_W(AW), .DATA_W(DW), .PERIOD(PER)) dut (
    .clk_15MHz(clk_15MHz), .rst_n(rst_n), .enable(enable), .mode(mode),
    .buf_we(buf_we), .buf_bank(buf_bank), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .tx_req_tgl(tx_req_tgl), .tx_bank(tx_bank), .tx_ack_tgl(tx_ack_tgl),
    .frame_seq(frame_seq), .busy(busy), .overrun(overrun)
  );

  always #5 clk_15MHz = ~clk_15MHz;
  int cyc = 0;
  always @(posedge clk_15MHz) cyc <= cyc + 1;

  typedef struct {logic bank; logic [AW-1:0] addr; logic [DW-1:0] data; int at;} wexp_t;
  typedef struct {logic bank; logic [15:0] seq; int tcyc;} pexp_t;
  wexp_t wq[$];
  pexp_t pq[$];

  int asrt = 0, fails = 0;
  task automatic chk(input bit ok, input string nm, input string msg);
    asrt++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: %s", nm, msg);
    end
  endtask

  // Frame-level reference state
  bit          hold = 1'b0;
  int          occupied = 0, run = 0, fill_end = -1, last_ack_cyc = -1000, ticks = 0, n_posts = 0;
  int          outstanding = 0, ack_dly = -1;
  logic [15:0] m_seq = 0, m_lfsr = 16'hACE1;
  logic        m_bank = 0, req_seen = 0;

  task automatic build_frame(input int t, input logic [1:0] md);
    logic [DW-1:0] w, sum;
    wexp_t e;
    pexp_t p;
    sum = '0;
    for (int k = 0; k < N; k++) begin
      if (k == 0)          w = 16'h5AA5;
      else if (k == 1)     w = m_seq;
      else if (k == N - 1) w = sum;
      else begin
        case (md)
          2'd0: w = DW'(k);
          2'd1: begin
            w = m_lfsr;
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
          end
          2'd2: w = 16'hA5A5;
          default: w = 16'h0001 << (k % 16);
        endcase
      end
      if (k < N - 1) sum = sum + w;
      e.bank = m_bank; e.addr = AW'(k); e.data = w; e.at = t + 1 + k;
      wq.push_back(e);
    end
    p.bank = m_bank; p.seq = m_seq; p.tcyc = t;
    pq.push_back(p);
    m_seq = m_seq + 16'd1;
    m_bank = ~m_bank;
    occupied++;
    fill_end = t + N;
  endtask

  // Model + consumer-side ack responder
  initial forever begin
    @(negedge clk_15MHz);
    if (!rst_n) begin
      occupied = 0; run = 0; fill_end = -1; outstanding = 0; ack_dly = -1;
      m_seq = 0; m_lfsr = 16'hACE1; m_bank = 0; req_seen = 0; tx_ack_tgl = 0;
      wq.delete(); pq.delete();
    end else begin
      if (tx_req_tgl != req_seen) begin
        req_seen = tx_req_tgl;
        outstanding++;
      end
      if (outstanding > 0 && !hold) begin
        if (ack_dly < 0) ack_dly = $urandom_range(20, 100);
        else if (ack_dly == 0) begin
          tx_ack_tgl = ~tx_ack_tgl;
          last_ack_cyc = cyc;
          outstanding--;
          occupied--;
          ack_dly = -1;
        end else ack_dly--;
      end
      if (enable) run++; else run = 0;
      if (enable && run % PER == 0) begin
        ticks++;
        if (!(cyc <= fill_end || occupied >= 2)) build_frame(cyc, mode);
      end
    end
  end

  // Monitor
  logic prev_req = 0;
  initial forever begin
    wexp_t e;
    pexp_t p;
    int exp_at;
    @(negedge clk_15MHz);
    if (!rst_n) prev_req = 0;
    else begin
      if (buf_we) begin
        if (wq.size() == 0)
          chk(0, "write_unexpected", $sformatf("bank=%0d addr=%0d data=%h cyc=%0d, no write required",
              buf_bank, buf_addr, buf_wdata, cyc));
        else begin
          e = wq.pop_front();
          chk(buf_bank == e.bank && buf_addr == e.addr && buf_wdata == e.data && cyc == e.at && busy,
              "write", $sformatf("got bank=%0d addr=%0d data=%h cyc=%0d busy=%0b, want bank=%0d addr=%0d data=%h cyc=%0d busy=1",
              buf_bank, buf_addr, buf_wdata, cyc, busy, e.bank, e.addr, e.data, e.at));
        end
      end
      if (tx_req_tgl != prev_req) begin
        prev_req = tx_req_tgl;
        n_posts++;
        if (pq.size() == 0)
          chk(0, "post_unexpected", $sformatf("tx_bank=%0d cyc=%0d, no post required", tx_bank, cyc));
        else begin
          p = pq.pop_front();
          exp_at = (p.tcyc + N + 1 > last_ack_cyc + 3) ? p.tcyc + N + 1 : last_ack_cyc + 3;
          chk(tx_bank == p.bank && frame_seq == p.seq && cyc == exp_at, "post",
              $sformatf("got bank=%0d seq=%0d cyc=%0d, want bank=%0d seq=%0d cyc=%0d",
              tx_bank, frame_seq, cyc, p.bank, p.seq, exp_at));
        end
      end
    end
  end

  task automatic step1();
    @(posedge clk_15MHz); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step1();
  endtask

  task automatic wait_posts(input int n, input int lim, input string nm);
    int target = n_posts + n;
    int k = 0;
    while (n_posts < target && k < lim) begin step1(); k++; end
    chk(n_posts >= target, nm, $sformatf("posts seen %0d, required %0d", n_posts - target + n, n));
  endtask

  task automatic wait_drain(input int lim, input string nm);
    int k = 0;
    while ((wq.size() != 0 || pq.size() != 0 || occupied != 0) && k < lim) begin step1(); k++; end
    chk(wq.size() == 0 && pq.size() == 0 && occupied == 0, nm,
        $sformatf("outstanding words=%0d posts=%0d frames=%0d, required all 0", wq.size(), pq.size(), occupied));
  endtask

  task automatic wait_write(input logic [AW-1:0] a, input int lim, input string nm);
    int k = 0;
    while (!(buf_we && buf_addr == a) && k < lim) begin step1(); k++; end
    chk(buf_we && buf_addr == a, nm, $sformatf("write to addr %0d not seen within %0d cycles", a, lim));
  endtask

  task automatic chk_zero(input string nm);
    chk(buf_we == 0,     {nm, "_we"},     $sformatf("got %0d want 0", buf_we));
    chk(buf_bank == 0,   {nm, "_bank"},   $sformatf("got %0d want 0", buf_bank));
    chk(buf_addr == 0,   {nm, "_addr"},   $sformatf("got %0d want 0", buf_addr));
    chk(buf_wdata == 0,  {nm, "_wdata"},  $sformatf("got %h want 0", buf_wdata));
    chk(tx_req_tgl == 0, {nm, "_req"},    $sformatf("got %0d want 0", tx_req_tgl));
    chk(tx_bank == 0,    {nm, "_txbank"}, $sformatf("got %0d want 0", tx_bank));
    chk(frame_seq == 0,  {nm, "_seq"},    $sformatf("got %0d want 0", frame_seq));
    chk(busy == 0,       {nm, "_busy"},   $sformatf("got %0d want 0", busy));
    chk(overrun == 0,    {nm, "_ovr"},    $sformatf("got %0d want 0", overrun));
  endtask

  initial begin
    int t0;
    idle(3);
    chk_zero("reset");
    rst_n = 1'b1;

    // Incrementing payload, prompt acks
    mode = 2'd0; enable = 1'b1;
    wait_posts(4, 4 * PER + 300, "posts_incr");
    wait_drain(300, "drain_incr");
    chk(overrun == 0, "ovr_incr", $sformatf("got %0d want 0", overrun));

    // LFSR payload across consecutive frames
    mode = 2'd1;
    wait_posts(3, 3 * PER + 300, "posts_lfsr");
    wait_drain(300, "drain_lfsr");

    // Random mode changes at arbitrary times
    repeat (8) begin
      mode = 2'($urandom_range(0, 3));
      idle($urandom_range(100, 500));
    end
    wait_drain(PER + 300, "drain_rand");
    chk(overrun == 0, "ovr_rand", $sformatf("got %0d want 0", overrun));

    // Withheld ack: in flight + pending, third tick is dropped
    hold = 1'b1;
    t0 = ticks;
    for (int k = 0; k < 3 * PER + 100 && ticks < t0 + 3; k++) step1();
    chk(ticks >= t0 + 3, "hold_ticks", $sformatf("ticks seen %0d want 3", ticks - t0));
    idle(2);
    chk(overrun == 1, "ovr_set", $sformatf("got %0d want 1", overrun));
    idle(10);
    hold = 1'b0;
    wait_drain(400, "drain_ack");

    // Reset in the middle of a fill
    mode = 2'd0;
    wait_write(AW'(7), PER + 100, "reach_addr7");
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    idle(3);
    rst_n = 1'b1;
    wait_posts(1, PER + 200, "posts_after_reset");
    wait_drain(300, "drain_reset");

    // Enable dropped mid-fill, then re-enabled
    wait_write(AW'(3), PER + 100, "reach_addr3");
    enable = 1'b0;
    wait_drain(200, "drain_disable");
    idle(1300);
    chk(busy == 0 && buf_we == 0, "quiet_disabled", $sformatf("busy=%0d we=%0d want 0 0", busy, buf_we));
    enable = 1'b1;
    wait_posts(1, PER + 200, "posts_reenable");
    wait_drain(300, "drain_reenable");
    chk(overrun == 0, "ovr_final", $sformatf("got %0d want 0", overrun));

    $display("End of test - %0d assertions evaluated, %0d failures", asrt, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
